// File: rtl/float_accumulator_if.sv
// Input operand stream and output result stream of float_accumulator.
// The accumulator is the slave on both streams; the environment is the master.
interface float_accumulator_if;
  logic        inValid;
  logic        inReady;
  logic [31:0] inData;
  logic        outValid;
  logic        outReady;
  logic [31:0] outData;

  modport master (
    output inValid, inData, outReady,
    input  inReady, outValid, outData
  );

  modport slave (
    input  inValid, inData, outReady,
    output inReady, outValid, outData
  );
endinterface

// File: rtl/float_accumulator.sv
// Streams IEEE-754 singles through an external combinational floatAdder and keeps the running sum.
// Optional NaN/Inf operand detection is built when FACC_ERR_CHECK_EN is defined.
module float_accumulator #(
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [CNT_W-1:0]     len,
  float_accumulator_if.slave   io,
  output logic [31:0]          addA,
  output logic [31:0]          addB,
  input  logic [31:0]          addSum,
  output logic                 busy,
  output logic                 errFlag
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic [CNT_W-1:0]   cnt_inc;
  logic               in_hs;

  assign cnt_inc = cnt_q + 1'b1;
  assign in_hs   = io.inValid && (state_q == ACCUM);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = '0;
          cnt_d   = '0;
          len_d   = len;
          state_d = (len == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (in_hs) begin
          acc_d = addSum;
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) state_d = DONE;
        end
      end
      DONE: begin
        // Release of the result wins over any start seen in the same cycle.
        if (io.outReady) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end

`ifdef FACC_ERR_CHECK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (state_q == IDLE && start) err_d = 1'b0;
    else if (in_hs && io.inData[30:23] == 8'hFF) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign errFlag = err_q;
`else
  assign errFlag = 1'b0;
`endif

  // The result and adder operand come from the registered sum, never from addSum.
  assign addA        = acc_q;
  assign addB        = io.inData;
  assign io.outData  = acc_q;
  assign io.inReady  = (state_q == ACCUM);
  assign io.outValid = (state_q == DONE);
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_float_accumulator.sv
// Directed bench for float_accumulator with a small positive-only float adder standing in for floatAdder.
module tb_float_accumulator;
  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  len;
  logic [31:0] add_a, add_b, add_sum;
  logic        busy, err_flag;
  int          n_vec, n_miss;

  float_accumulator_if io ();

  float_accumulator #(.CNT_W(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .len     (len),
    .io      (io),
    .addA    (add_a),
    .addB    (add_b),
    .addSum  (add_sum),
    .busy    (busy),
    .errFlag (err_flag)
  );

  // Exact for the small positive operands used here; NaN/Inf in gives quiet NaN.
  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    logic [7:0]  e;
    logic [24:0] ma, mb, s;
    if (a[30:0] == '0) return b;
    if (b[30:0] == '0) return a;
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return 32'h7FC00000;
    ma = {2'b01, a[22:0]};
    mb = {2'b01, b[22:0]};
    if (a[30:23] >= b[30:23]) begin
      e  = a[30:23];
      mb = mb >> (a[30:23] - b[30:23]);
    end else begin
      e  = b[30:23];
      ma = ma >> (b[30:23] - a[30:23]);
    end
    s = ma + mb;
    if (s[24]) begin
      s = s >> 1;
      e = e + 8'd1;
    end
    return {1'b0, e, s[22:0]};
  endfunction

  assign add_sum = fadd(add_a, add_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [31:0] d);
    io.inValid = 1'b1;
    io.inData  = d;
    tick();
    io.inValid = 1'b0;
  endtask

  task automatic kick(input logic [7:0] n);
    start = 1'b1;
    len   = n;
    tick();
    start = 1'b0;
  endtask

  task automatic release_result();
    io.outReady = 1'b1;
    tick();
    io.outReady = 1'b0;
  endtask

  initial begin
    n_vec       = 0;
    n_miss      = 0;
    rst_n       = 1'b0;
    start       = 1'b0;
    len         = 8'd0;
    io.inValid  = 1'b0;
    io.inData   = 32'h12345678;
    io.outReady = 1'b0;
    tick();
    tick();

    chk("rst_busy",     {31'd0, busy},        32'd0);
    chk("rst_outvalid", {31'd0, io.outValid}, 32'd0);
    chk("rst_inready",  {31'd0, io.inReady},  32'd0);
    chk("rst_outdata",  io.outData,           32'd0);
    chk("rst_adda",     add_a,                32'd0);
    chk("rst_addb",     add_b,                32'h12345678);
    chk("rst_err",      {31'd0, err_flag},    32'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_inready", {31'd0, io.inReady},  32'd0);

    // 1 + 2 + 3 = 6
    kick(8'd3);
    chk("run3_inready", {31'd0, io.inReady},  32'd1);
    chk("run3_busy",    {31'd0, busy},        32'd1);
    feed(32'h3F800000);
    chk("run3_first",   add_a,                32'h3F800000);
    feed(32'h40000000);
    chk("run3_second",  add_a,                32'h40400000);
    chk("run3_notdone", {31'd0, io.outValid}, 32'd0);
    feed(32'h40400000);
    chk("run3_valid",   {31'd0, io.outValid}, 32'd1);
    chk("run3_sum",     io.outData,           32'h40C00000);
    chk("run3_noready", {31'd0, io.inReady},  32'd0);
    release_result();
    chk("run3_idle",    {31'd0, busy},        32'd0);
    chk("run3_ovlow",   {31'd0, io.outValid}, 32'd0);

    // Zero-length run goes straight to DONE with a cleared sum.
    kick(8'd0);
    chk("len0_valid",   {31'd0, io.outValid}, 32'd1);
    chk("len0_data",    io.outData,           32'd0);
    chk("len0_inready", {31'd0, io.inReady},  32'd0);
    release_result();
    chk("len0_idle",    {31'd0, busy},        32'd0);

    // Four ones with stalls; len port changes mid-run and must be ignored.
    kick(8'd4);
    len = 8'd1;
    feed(32'h3F800000);
    io.inData = 32'h40000000;
    tick();
    chk("gap_acc1",     add_a,                32'h3F800000);
    tick();
    chk("gap_acc2",     add_a,                32'h3F800000);
    chk("gap_inready",  {31'd0, io.inReady},  32'd1);
    feed(32'h3F800000);
    chk("gap_after1",   {31'd0, io.outValid}, 32'd0);
    tick();
    tick();
    feed(32'h3F800000);
    chk("gap_after2",   {31'd0, io.outValid}, 32'd0);
    feed(32'h3F800000);
    chk("gap_valid",    {31'd0, io.outValid}, 32'd1);
    chk("gap_sum",      io.outData,           32'h40800000);

    // Hold in DONE while start pulses are ignored.
    for (int i = 0; i < 5; i++) begin
      start = i[0];
      len   = 8'd7;
      tick();
      chk("hold_valid", {31'd0, io.outValid}, 32'd1);
      chk("hold_data",  io.outData,           32'h40800000);
    end
    start       = 1'b1;
    io.outReady = 1'b1;
    tick();
    start       = 1'b0;
    io.outReady = 1'b0;
    chk("hold_idle",    {31'd0, busy},        32'd0);
    tick();
    chk("hold_stay",    {31'd0, busy},        32'd0);

    // Asynchronous reset mid-run discards the partial sum.
    kick(8'd4);
    feed(32'h3F800000);
    feed(32'h40000000);
    chk("ar_partial",   add_a,                32'h40400000);
    rst_n = 1'b0;
    #1;
    chk("ar_adda",      add_a,                32'd0);
    chk("ar_busy",      {31'd0, busy},        32'd0);
    chk("ar_inready",   {31'd0, io.inReady},  32'd0);
    chk("ar_outdata",   io.outData,           32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    kick(8'd1);
    feed(32'h3F800000);
    chk("ar_valid",     {31'd0, io.outValid}, 32'd1);
    chk("ar_sum",       io.outData,           32'h3F800000);
    release_result();

    // NaN operand flagging.
    kick(8'd2);
    feed(32'h7FC00000);
    feed(32'h3F800000);
    chk("err_valid",    {31'd0, io.outValid}, 32'd1);
`ifdef FACC_ERR_CHECK_EN
    chk("err_set",      {31'd0, err_flag},    32'd1);
    release_result();
    chk("err_sticky",   {31'd0, err_flag},    32'd1);
`else
    chk("err_set",      {31'd0, err_flag},    32'd0);
    release_result();
    chk("err_sticky",   {31'd0, err_flag},    32'd0);
`endif
    kick(8'd1);
    chk("err_clear",    {31'd0, err_flag},    32'd0);
    feed(32'h40000000);
    chk("err_run_sum",  io.outData,           32'h40000000);
    release_result();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
